// File: rtl/stream_demux_1_to_4_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_to_4_if
// Description : Handshake bundle for the 1-to-4 stream demultiplexer. It holds
//               one valid/ready input stream with a 2-bit destination select,
//               and four valid/ready output channels packed side by side.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_1_to_4_if #(
    parameter int size = 10
);
    logic [size-1:0]   in_data;
    logic [1:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [4*size-1:0] out_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;

    // Environment side: sources the input stream and sinks the four channels.
    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    // Demultiplexer side.
    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux_1_to_4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_to_4
// Description : Registered 1-to-4 stream demultiplexer. Each input beat is
//               steered to the channel named by in_sel and lands in that
//               channel's one-entry buffer, so a stalled channel never blocks
//               the other three. Each channel also keeps a saturating count of
//               beats delivered to its sink.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_to_4 #(
    parameter int size  = 10,
    parameter int CNT_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    stream_demux_1_to_4_if.slave      bus,
    output logic [4*CNT_W-1:0]        cnt,
    input  wire logic                 cnt_clr
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        w_valid;
    logic [4*size-1:0] w_data;
    logic [3:0]        w_accept;

    // A beat can enter whenever its destination buffer is empty or is being
    // drained this very cycle; in_valid deliberately plays no part here.
    assign bus.in_ready = !w_valid[bus.in_sel] || bus.out_ready[bus.in_sel];

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            localparam logic [1:0] c_IDX = 2'(i);

            logic            r_valid;
            logic [size-1:0] r_data;
            logic [CNT_W-1:0] r_cnt;
            logic            w_load;
            logic            w_pop;

            assign w_load = bus.in_valid && bus.in_ready && (bus.in_sel == c_IDX);
            assign w_pop  = r_valid && bus.out_ready[i];

            assign w_accept[i]            = w_load;
            assign w_valid[i]             = r_valid;
            assign w_data[i*size +: size] = r_data;
            assign cnt[i*CNT_W +: CNT_W]  = r_cnt;

            // One-entry buffer: a load wins over a pop, which keeps the channel
            // full and gives one beat per clock when the sink is always ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load) begin
                    r_valid <= 1'b1;
                    r_data  <= bus.in_data;
                end else if (w_pop) begin
                    r_valid <= 1'b0;
                end
            end

            // Delivered-beat counter: clear beats a same-cycle increment, and
            // the count sticks at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_pop && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    endgenerate

    // Accept strobes are kept for debug probing only.
    logic w_unused;
    assign w_unused = ^w_accept;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_to_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_to_4
// Description : Directed bench for the 1-to-4 stream demultiplexer with a
//               per-channel expected-data scoreboard and an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_to_4;

    localparam int SZ = 10;
    localparam int CW = 3;

    logic            clk;
    logic            rst_n;
    logic [4*CW-1:0] cnt;
    logic            cnt_clr;

    stream_demux_1_to_4_if #(.size(SZ)) bus ();

    stream_demux_1_to_4 #(.size(SZ), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt     (cnt),
        .cnt_clr (cnt_clr)
    );

    int checks   = 0;
    int failures = 0;

    logic [SZ-1:0] exp_q [4][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SZ-1:0] data_of(input int ch);
        return bus.out_data[ch*SZ +: SZ];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return cnt[ch*CW +: CW];
    endfunction

    // Call on a negedge; returns on the negedge following acceptance.
    task automatic send(input logic [1:0] ch, input logic [SZ-1:0] d);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = ch;
        bus.in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (bus.in_ready) begin
                exp_q[ch].push_back(d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    // Monitor: every valid channel must match the head of its queue; a
    // valid/ready handshake pops it. Sampled well clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.out_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check($sformatf("phantom_beat_ch%0d", i), 32'd1, 32'd0);
                        end else begin
                            check($sformatf("data_ch%0d", i), 32'(data_of(i)), 32'(exp_q[i][0]));
                            if (bus.out_ready[i]) void'(exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_cnt",       32'(cnt),           32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic routing: one beat per channel on consecutive cycles.
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel  = 2'(k);
            bus.in_data = 10'(100 * (k + 1));
            #1;
            check("basic_in_ready", 32'(bus.in_ready), 32'd1);
            exp_q[k].push_back(10'(100 * (k + 1)));
            if (k > 0) check("basic_valid_pulse", 32'(bus.out_valid), 32'(4'b0001 << (k - 1)));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        check("basic_valid_last", 32'(bus.out_valid), 32'b1000);
        @(negedge clk);
        #1;
        check("basic_valid_idle", 32'(bus.out_valid), 32'd0);
        check("basic_cnt", 32'(cnt), 32'({3'd1, 3'd1, 3'd1, 3'd1}));
        @(negedge clk);

        // Backpressure on channel 2, other channels keep flowing.
        bus.out_ready = 4'b1011;
        send(2'd2, 10'd300);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 10'd301;
        #1;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_ch2_held", 32'(data_of(2)), 32'd300);
        @(negedge clk);
        #1;
        check("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
        check("bp_ch2_valid", 32'(bus.out_valid[2]), 32'd1);
        @(negedge clk);
        send(2'd0, 10'd100);
        #1;
        check("bp_ch0_valid", 32'(bus.out_valid[0]), 32'd1);
        check("bp_ch2_still_valid", 32'(bus.out_valid[2]), 32'd1);
        @(negedge clk);
        bus.out_ready = 4'b1111;
        send(2'd2, 10'd301);
        repeat (3) @(negedge clk);
        #1;
        check("bp_cnt", 32'(cnt), 32'({3'd1, 3'd3, 3'd1, 3'd2}));
        @(negedge clk);

        // Same-edge pop and push on channel 1.
        bus.out_ready = 4'b1101;
        send(2'd1, 10'd200);
        bus.out_ready = 4'b1111;
        send(2'd1, 10'd201);
        #1;
        check("pp_valid_kept", 32'(bus.out_valid[1]), 32'd1);
        check("pp_data_new", 32'(data_of(1)), 32'd201);
        check("pp_cnt1", 32'(cnt_of(1)), 32'd2);
        @(negedge clk);
        #1;
        check("pp_valid_drop", 32'(bus.out_valid[1]), 32'd0);
        check("pp_cnt1_after", 32'(cnt_of(1)), 32'd3);
        @(negedge clk);

        // Counter saturation on channel 3, then clear on a pop cycle.
        for (int k = 0; k < 9; k++) send(2'd3, 10'(500 + k));
        repeat (2) @(negedge clk);
        #1;
        check("sat_cnt3", 32'(cnt_of(3)), 32'd7);
        @(negedge clk);
        bus.out_ready = 4'b0111;
        send(2'd3, 10'd600);
        bus.out_ready = 4'b1111;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        check("clr_cnt_all", 32'(cnt), 32'd0);
        check("clr_ch3_popped", 32'(bus.out_valid[3]), 32'd0);
        @(negedge clk);

        // Asynchronous reset with two full channels.
        send(2'd1, 10'd123);
        bus.out_ready = 4'b0010;
        send(2'd0, 10'd111);
        send(2'd2, 10'd222);
        #1;
        check("rst2_pre_valid", 32'(bus.out_valid), 32'b0101);
        check("rst2_pre_cnt", 32'(cnt), 32'({3'd0, 3'd0, 3'd1, 3'd0}));
        #2;
        rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[2].delete();
        #1;
        check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst2_out_data", 32'(bus.out_data), 32'd0);
        check("rst2_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rst2_no_stale", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        #3;
        for (int i = 0; i < 4; i++)
            check($sformatf("drain_ch%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_demux_1_to_4.md
Name: stream_demux_1_to_4

Overview:
- Registered 1-to-4 stream demultiplexer: the routing counterpart of the team's 4-to-1 mux.
- Steers one valid/ready input stream to one of four output channels, chosen per beat by a 2-bit select.
- Each channel owns a one-entry output buffer, so channels backpressure independently.
- Each channel also owns a saturating delivered-beat counter, used for debug and bench checking.

Parameters:
- size, 10, data width of input and of each output channel
- CNT_W, 8, width of each per-channel delivered-beat counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  size  input beat payload
- in_sel  input  2  destination channel of the current input beat (0..3)
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the beat on in_sel this cycle
- out_data  output  4*size  channel i payload in bits [i*size +: size]
- out_valid  output  4  bit i: channel i buffer holds a beat
- out_ready  input  4  bit i: channel i sink accepts
- cnt  output  4*CNT_W  channel i delivered-beat count in bits [i*CNT_W +: CNT_W]
- cnt_clr  input  1  synchronous clear of all four counters

Behaviour:
- Reset:
  - Clock is clk.
  - Reset is rst_n: asynchronous, active-low.
  - While rst_n=0: out_valid=0, out_data=0, cnt=0.
  - Any buffered beats are discarded; they are not delivered after reset release.
- Input ready:
  - in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - This is purely combinational and is evaluated even when in_valid=0.
  - in_ready never depends on in_valid.
- Input transfer:
  - A transfer occurs on a clk edge when in_valid && in_ready.
  - At that edge, buffer[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency is one cycle: the beat appears on channel in_sel the cycle after acceptance.
- Output transfer:
  - An output transfer occurs on channel i when out_valid[i] && out_ready[i].
  - If channel i is not loaded at the same edge, out_valid[i] <= 0.
- Simultaneous pop and load on the same channel:
  - out_valid stays 1 and the buffer takes the new beat.
  - Sustained throughput is therefore one beat per clock per channel.
- Channel independence:
  - Channels not addressed by an accepted input beat hold their data and valid.
  - A stalled channel never blocks beats addressed to other channels.
- out_data when out_valid[i]=0:
  - Holds the last delivered value (0 after reset).
  - Sinks must ignore it.
- Input beats not accepted (in_valid && !in_ready):
  - No state change.
  - The source must hold in_data and in_sel stable until accepted.
- in_sel changes while in_valid=0 are legal and cause no state change.
- Counters:
  - cnt[i] increments by 1 on each output transfer on channel i.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets all counters to 0 at the edge.
  - cnt_clr has priority over a simultaneous increment: result is 0, and that beat is not counted.
- No internal FSM beyond the per-channel valid bits.
- Outputs out_valid, out_data and cnt are driven only from registers.

Test Plan:
- Basic routing:
  - Stimulus: size=10, out_ready=4'b1111; send 100,200,300,400 with in_sel=0,1,2,3 on consecutive cycles.
  - Response: each value appears on its channel exactly one cycle after acceptance with out_valid pulsing one cycle; in_ready=1 throughout; cnt=1,1,1,1.
- Backpressure:
  - Stimulus: out_ready[2]=0; send 300 then 301 to channel 2.
  - Response: 300 accepted; in_ready=0 while in_sel=2, and channel 2 holds 300.
  - Stimulus: switch to in_sel=0 with data 100.
  - Response: accepted immediately; channel 0 delivers 100.
  - Stimulus: raise out_ready[2].
  - Response: 300 delivered, then 301 accepted and delivered.
- Same-edge pop and push:
  - Stimulus: channel 1 holds 200 with out_ready[1]=1; send 201 to channel 1 that cycle.
  - Response: accepted; next cycle out_data ch1=201 and out_valid[1] stays 1; cnt[1] +1.
- Counter saturation and clear:
  - Stimulus: CNT_W=3; deliver 9 beats on channel 3.
  - Response: cnt[3]=7.
  - Stimulus: assert cnt_clr on the same cycle as a channel 3 pop.
  - Response: cnt[3]=0 next cycle.
- Reset mid-operation:
  - Stimulus: channels 0 and 2 full with out_ready=0; pulse rst_n low asynchronously between edges.
  - Response: out_valid=0, out_data=0 and cnt=0 immediately; no delivery of the old beats after release; in_ready=1.
